// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core blocks: sequencer state encoding,
// special instruction encodings and the default reset PC.
package npc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } npc_state_e;

    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/npc_perf_cnt.sv
// Free-running 64-bit cycle and retired-instruction counters for the NPC
// sequencer; both wrap naturally at 2^64.
module npc_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        cycle_en,
    input  logic        retire_en,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycle   <= 64'd0;
            perf_instret <= 64'd0;
        end else begin
            if (cycle_en)
                perf_cycle <= perf_cycle + 64'd1;
            if (retire_en)
                perf_instret <= perf_instret + 64'd1;
        end
    end

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle sequencer for the NPC core: fetch, latch, execute/commit, halt.
// Optional performance counters are built when NPC_CTRL_PERF_EN is defined.
module npc_ctrl
    import npc_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = DATA_LEN'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                inst_req_valid,
    output logic [DATA_LEN-1:0] inst_req_addr,
    input  logic                inst_req_ready,
    input  logic                inst_rsp_valid,
    input  logic [31:0]         inst_rsp_data,
    output logic [31:0]         inst,
    input  logic                dec_op,
    input  logic [4:0]          dec_rd,
    input  logic [DATA_LEN-1:0] exu_result,
    input  logic [DATA_LEN-1:0] a0_val,
    output logic                rf_wen,
    output logic [4:0]          rf_waddr,
    output logic [DATA_LEN-1:0] rf_wdata,
    output logic [DATA_LEN-1:0] pc,
    output logic                halt,
    output logic                halt_illegal,
    output logic [DATA_LEN-1:0] halt_ret
`ifdef NPC_CTRL_PERF_EN
    ,
    output logic [63:0]         perf_cycle,
    output logic [63:0]         perf_instret
`endif
);

    npc_state_e state_q, state_d;
    logic       is_ebreak;
    logic       exec_retire;

    assign is_ebreak     = (inst == INST_EBREAK);
    assign exec_retire   = (state_q == EXEC) && !is_ebreak && dec_op;
    assign inst_req_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (inst_req_ready) state_d = WAIT;
            WAIT:  if (inst_rsp_valid) state_d = EXEC;
            EXEC:  state_d = exec_retire ? FETCH : HALT;
            HALT:  state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Valid is decoded from state alone, so ready never feeds back into it.
    always_comb begin
        inst_req_valid = 1'b0;
        rf_wen         = 1'b0;
        rf_waddr       = 5'd0;
        rf_wdata       = '0;
        if (state_q == FETCH)
            inst_req_valid = 1'b1;
        if (exec_retire) begin
            rf_waddr = dec_rd;
            rf_wdata = exu_result;
            rf_wen   = (dec_rd != 5'd0);
        end
    end

    // PC, instruction register and sticky halt information.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            inst         <= 32'h0;
            halt         <= 1'b0;
            halt_illegal <= 1'b0;
            halt_ret     <= '0;
        end else begin
            if (state_q == WAIT && inst_rsp_valid)
                inst <= inst_rsp_data;
            if (state_q == EXEC) begin
                if (is_ebreak) begin
                    halt     <= 1'b1;
                    halt_ret <= a0_val;
                end else if (dec_op) begin
                    pc <= pc + DATA_LEN'(4);
                end else begin
                    halt         <= 1'b1;
                    halt_illegal <= 1'b1;
                    halt_ret     <= pc;
                end
            end
        end
    end

`ifdef NPC_CTRL_PERF_EN
    npc_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst          (rst),
        .cycle_en     (state_q != HALT),
        .retire_en    (exec_retire),
        .perf_cycle   (perf_cycle),
        .perf_instret (perf_instret)
    );
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Self-checking bench for npc_ctrl: a cycle-by-cycle vector table plus
// hand-written ebreak / reset-restart sequence. Honours NPC_CTRL_PERF_EN.
module tb_npc_ctrl;

    localparam logic [31:0] P0 = 32'h8000_0000;
    localparam logic [31:0] P1 = 32'h8000_0004;
    localparam logic [31:0] P2 = 32'h8000_0008;
    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_ADDI0 = 32'h0010_0013;
    localparam logic [31:0] I_ILL   = 32'h0000_0033;
    localparam logic [31:0] I_EBRK  = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_valid;
    logic [31:0] inst_req_addr;
    logic        inst_req_ready = 1'b0;
    logic        inst_rsp_valid = 1'b0;
    logic [31:0] inst_rsp_data = 32'h0;
    logic [31:0] inst;
    logic        dec_op = 1'b0;
    logic [4:0]  dec_rd = 5'd0;
    logic [31:0] exu_result = 32'h0;
    logic [31:0] a0_val = 32'h0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        halt;
    logic        halt_illegal;
    logic [31:0] halt_ret;
`ifdef NPC_CTRL_PERF_EN
    logic [63:0] perf_cycle;
    logic [63:0] perf_instret;
`endif

    int errors = 0;
    int checks = 0;

    npc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req_valid (inst_req_valid),
        .inst_req_addr  (inst_req_addr),
        .inst_req_ready (inst_req_ready),
        .inst_rsp_valid (inst_rsp_valid),
        .inst_rsp_data  (inst_rsp_data),
        .inst           (inst),
        .dec_op         (dec_op),
        .dec_rd         (dec_rd),
        .exu_result     (exu_result),
        .a0_val         (a0_val),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .pc             (pc),
        .halt           (halt),
        .halt_illegal   (halt_illegal),
        .halt_ret       (halt_ret)
`ifdef NPC_CTRL_PERF_EN
        ,
        .perf_cycle     (perf_cycle),
        .perf_instret   (perf_instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        op;
        logic [4:0]  rd;
        logic [31:0] exu;
        logic [31:0] a0;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_pc;
        logic        e_halt;
        logic        e_ill;
        logic [31:0] e_ret;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        inst_req_ready = v.ready;
        inst_rsp_valid = v.rsp_v;
        inst_rsp_data  = v.rsp_d;
        dec_op         = v.op;
        dec_rd         = v.rd;
        exu_result     = v.exu;
        a0_val         = v.a0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d valid", i), 64'(inst_req_valid), 64'(v.e_valid));
        checkOutput($sformatf("v%0d addr", i), 64'(inst_req_addr), 64'(v.e_pc));
        checkOutput($sformatf("v%0d inst", i), 64'(inst), 64'(v.e_inst));
        checkOutput($sformatf("v%0d rf_wen", i), 64'(rf_wen), 64'(v.e_wen));
        checkOutput($sformatf("v%0d rf_waddr", i), 64'(rf_waddr), 64'(v.e_waddr));
        checkOutput($sformatf("v%0d rf_wdata", i), 64'(rf_wdata), 64'(v.e_wdata));
        checkOutput($sformatf("v%0d pc", i), 64'(pc), 64'(v.e_pc));
        checkOutput($sformatf("v%0d halt", i), 64'(halt), 64'(v.e_halt));
        checkOutput($sformatf("v%0d halt_illegal", i), 64'(halt_illegal), 64'(v.e_ill));
        checkOutput($sformatf("v%0d halt_ret", i), 64'(halt_ret), 64'(v.e_ret));
    endtask

    initial begin
        // One entry per clock cycle starting with the IDLE cycle after reset release.
        vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'h0,   1'b0, 5'd0, 32'd0, P0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h0,   1'b0, 5'd0, 32'd0, P0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, I_ADDI, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'h0,   1'b0, 5'd0, 32'd0, P0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 5'd1, 32'd5, 32'd0, 1'b0, I_ADDI,  1'b1, 5'd1, 32'd5, P0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'hdeadbeef, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, I_ADDI, 1'b0, 5'd0, 32'd0, P1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 32'd0, 32'd0, 1'b1, I_ADDI,  1'b0, 5'd0, 32'd0, P1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 32'd0, 32'd0, 1'b1, I_ADDI,  1'b0, 5'd0, 32'd0, P1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 32'd0, 32'd0, 1'b0, I_ADDI,  1'b0, 5'd0, 32'd0, P1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, I_ADDI0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, I_ADDI, 1'b0, 5'd0, 32'd0, P1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 5'd0, 32'd1, 32'd0, 1'b0, I_ADDI0, 1'b0, 5'd0, 32'd1, P1, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 32'd0, 32'd0, 1'b1, I_ADDI0, 1'b0, 5'd0, 32'd0, P2, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, I_ILL,  1'b0, 5'd0, 32'd0, 32'd0, 1'b0, I_ADDI0, 1'b0, 5'd0, 32'd0, P2, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 32'd0, 32'd7, 1'b0, I_ILL,   1'b0, 5'd0, 32'd0, P2, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b1, I_ADDI, 1'b1, 5'd3, 32'd9, 32'd7, 1'b0, I_ILL,   1'b0, 5'd0, 32'd0, P2, 1'b1, 1'b1, P2};
        vecs[16] = vecs[15];

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset valid", 64'(inst_req_valid), 64'd0);
        checkOutput("reset pc", 64'(pc), 64'(P0));
        checkOutput("reset inst", 64'(inst), 64'd0);
        checkOutput("reset rf_wen", 64'(rf_wen), 64'd0);
        checkOutput("reset halt", 64'(halt), 64'd0);
        checkOutput("reset halt_illegal", 64'(halt_illegal), 64'd0);
        checkOutput("reset halt_ret", 64'(halt_ret), 64'd0);
`ifdef NPC_CTRL_PERF_EN
        checkOutput("reset perf_cycle", perf_cycle, 64'd0);
        checkOutput("reset perf_instret", perf_instret, 64'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkVector(i, vecs[i]);
            stepCycle();
        end

`ifdef NPC_CTRL_PERF_EN
        // Fifteen non-HALT cycles (vectors 0..14) elapsed before the halt.
        checkOutput("perf_instret", perf_instret, 64'd2);
        checkOutput("perf_cycle frozen", perf_cycle, 64'd15);
        repeat (5) stepCycle();
        checkOutput("perf_cycle frozen later", perf_cycle, 64'd15);
`endif

        // Ebreak takes priority over dec_op and captures a0 as exit code.
        rst = 1'b1;
        #1;
        checkOutput("mid reset halt", 64'(halt), 64'd0);
        checkOutput("mid reset pc", 64'(pc), 64'(P0));
        stepCycle();
        rst = 1'b0;
        applyStimulus('{1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0, 32'd0,
                        1'b0, 32'h0, 1'b0, 5'd0, 32'd0, P0, 1'b0, 1'b0, 32'h0});
        stepCycle();
        #1;
        checkOutput("ebrk fetch valid", 64'(inst_req_valid), 64'd1);
        stepCycle();
        inst_req_ready = 1'b0;
        inst_rsp_valid = 1'b1;
        inst_rsp_data  = I_EBRK;
        stepCycle();
        inst_rsp_valid = 1'b0;
        dec_op         = 1'b1;
        dec_rd         = 5'd5;
        exu_result     = 32'd7;
        a0_val         = 32'd0;
        #1;
        checkOutput("ebrk exec rf_wen", 64'(rf_wen), 64'd0);
        checkOutput("ebrk exec inst", 64'(inst), 64'(I_EBRK));
        stepCycle();
        a0_val         = 32'h1234;
        inst_req_ready = 1'b1;
        inst_rsp_valid = 1'b1;
        #1;
        checkOutput("ebrk halt", 64'(halt), 64'd1);
        checkOutput("ebrk halt_illegal", 64'(halt_illegal), 64'd0);
        checkOutput("ebrk halt_ret", 64'(halt_ret), 64'd0);
        checkOutput("ebrk pc", 64'(pc), 64'(P0));
        for (int c = 0; c < 20; c++) begin
            checkOutput($sformatf("halted c%0d valid", c), 64'(inst_req_valid), 64'd0);
            checkOutput($sformatf("halted c%0d rf_wen", c), 64'(rf_wen), 64'd0);
            stepCycle();
        end
        checkOutput("halted halt_ret held", 64'(halt_ret), 64'd0);
        checkOutput("halted halt held", 64'(halt), 64'd1);

        rst = 1'b1;
        inst_rsp_valid = 1'b0;
        #1;
        checkOutput("restart reset halt", 64'(halt), 64'd0);
        checkOutput("restart reset valid", 64'(inst_req_valid), 64'd0);
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("restart idle valid", 64'(inst_req_valid), 64'd0);
        stepCycle();
        checkOutput("restart fetch valid", 64'(inst_req_valid), 64'd1);
        checkOutput("restart fetch addr", 64'(inst_req_addr), 64'(P0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
